// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory access controller
// Also carries the common.vh load/store encodings, guarded so a real common.vh takes precedence.
`ifndef MEM_LOAD
`define MEM_LOAD 2'b01
`endif
`ifndef MEM_STOR
`define MEM_STOR 2'b10
`endif

package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;
  localparam logic       LANE_H_HI = 1'b1;

  // Sub-word stores replicate the data across all lanes; the bus picks the lane from the address.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: store_lanes = {4{wd[7:0]}};
      SZ_HALF: store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - pipeline and data-bus signals of the memory access controller
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_en_i;
  logic [1:0]        mem_type_i;
  logic [1:0]        mem_size_i;
  logic              mem_signed_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic              flush_i;

  logic              data_req_o;
  logic              data_wr_o;
  logic [1:0]        data_size_o;
  logic [ADDR_W-1:0] data_addr_o;
  logic [31:0]       data_wdata_o;
  logic              data_addr_ok_i;
  logic              data_data_ok_i;
  logic [31:0]       data_rdata_i;

  logic              mem_stall_o;
  logic              data_ok_o;
  logic [31:0]       rdata_o;
  logic              addr_err_o;

  modport slave (
    input  mem_en_i, mem_type_i, mem_size_i, mem_signed_i, addr_i, wdata_i, flush_i,
    input  data_addr_ok_i, data_data_ok_i, data_rdata_i,
    output data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o,
    output mem_stall_o, data_ok_o, rdata_o, addr_err_o
  );

  modport master (
    output mem_en_i, mem_type_i, mem_size_i, mem_signed_i, addr_i, wdata_i, flush_i,
    output data_addr_ok_i, data_data_ok_i, data_rdata_i,
    input  data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o,
    input  mem_stall_o, data_ok_o, rdata_o, addr_err_o
  );
endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/half lane of a read word and extends it to 32 bits
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (lane_i)
      LANE_B0: byte_sel = rdata_i[7:0];
      LANE_B1: byte_sel = rdata_i[15:8];
      LANE_B2: byte_sel = rdata_i[23:16];
      LANE_B3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase

    half_sel = rdata_i[15:0];
    if (lane_i[1] == LANE_H_HI) half_sel = rdata_i[31:16];

    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer for a req/addr_ok/data_ok data bus
// Flushes that arrive after a request is issued still drain the response so the bus stays in step.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  mem_access_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       resp_q, resp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       aligned;
  logic              misalign;

  load_align u_load_align (
    .rdata_i  (resp_q),
    .lane_i   (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (aligned)
  );

  assign misalign = ((bus.mem_size_i == SZ_WORD) && (bus.addr_i[1:0] != 2'b00)) ||
                    ((bus.mem_size_i == SZ_HALF) && bus.addr_i[0]);

  always_comb begin
    state_d        = state_q;
    drop_d         = drop_q;
    addr_d         = addr_q;
    store_d        = store_q;
    size_d         = size_q;
    signed_d       = signed_q;
    wdata_d        = wdata_q;
    resp_d         = resp_q;
    rdata_d        = rdata_q;
    bus.data_req_o  = 1'b0;
    bus.mem_stall_o = 1'b0;
    bus.data_ok_o   = 1'b0;
    bus.addr_err_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        // rst gating keeps the combinational outputs quiet while reset is held
        if (!rst && bus.mem_en_i) begin
          if (misalign) begin
            bus.addr_err_o = 1'b1;
          end else if (!bus.flush_i) begin
            addr_d          = bus.addr_i;
            store_d         = (bus.mem_type_i == `MEM_STOR);
            size_d          = bus.mem_size_i;
            signed_d        = bus.mem_signed_i;
            wdata_d         = store_lanes(bus.mem_size_i, bus.wdata_i);
            bus.mem_stall_o = 1'b1;
            state_d         = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        bus.data_req_o  = 1'b1;
        bus.mem_stall_o = 1'b1;
        if (bus.flush_i) drop_d = 1'b1;
        if (bus.data_addr_ok_i) begin
          if (bus.data_data_ok_i) begin
            resp_d  = bus.data_rdata_i;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        bus.mem_stall_o = 1'b1;
        if (bus.flush_i) drop_d = 1'b1;
        if (bus.data_data_ok_i) begin
          resp_d  = bus.data_rdata_i;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.mem_stall_o = drop_q;
        if (!drop_q && !bus.flush_i) begin
          bus.data_ok_o = 1'b1;
          if (!store_q) rdata_d = aligned;
        end
        drop_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rdata_o shows the committed value already in DONE and holds it afterwards
  assign bus.rdata_o      = rdata_d;
  assign bus.data_wr_o    = store_q;
  assign bus.data_size_o  = size_q;
  assign bus.data_addr_o  = addr_q;
  assign bus.data_wdata_o = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      drop_q   <= 1'b0;
      addr_q   <= '0;
      store_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      resp_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
`ifndef MEM_LOAD
`define MEM_LOAD 2'b01
`endif
`ifndef MEM_STOR
`define MEM_STOR 2'b10
`endif

module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.mem_en_i       = 1'b0;
    bus.mem_type_i     = `MEM_LOAD;
    bus.mem_size_i     = SZ_WORD;
    bus.mem_signed_i   = 1'b0;
    bus.addr_i         = 32'h0;
    bus.wdata_i        = 32'h0;
    bus.flush_i        = 1'b0;
    bus.data_addr_ok_i = 1'b0;
    bus.data_data_ok_i = 1'b0;
    bus.data_rdata_i   = 32'h0;
  endtask

  task automatic set_op(input logic [1:0] typ, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] a, input logic [31:0] wd);
    bus.mem_en_i     = 1'b1;
    bus.mem_type_i   = typ;
    bus.mem_size_i   = sz;
    bus.mem_signed_i = sgn;
    bus.addr_i       = a;
    bus.wdata_i      = wd;
  endtask

  // Called at posedge+1 in IDLE; acts as the bus slave and samples the DONE cycle.
  task automatic run_txn(input logic [1:0] typ, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int addr_wait, input int data_wait, input logic [31:0] rd,
                         input int flush_at,
                         output int stall_cnt, output logic ok_done, output logic stall_done,
                         output logic [31:0] rd_done, output logic [31:0] req_addr,
                         output logic [31:0] req_wdata, output logic [1:0] req_size,
                         output logic req_wr);
    int req_cnt = 0;
    int wait_cnt = -1;
    bit resp_sent = 0;
    bit done = 0;
    stall_cnt = 0; ok_done = 0; stall_done = 0; rd_done = 0;
    req_addr = 0; req_wdata = 0; req_size = 0; req_wr = 0;
    set_op(typ, sz, sgn, a, wd);
    for (int c = 0; c < 40 && !done; c++) begin
      bus.flush_i        = (c == flush_at);
      bus.data_addr_ok_i = 1'b0;
      bus.data_data_ok_i = 1'b0;
      if (resp_sent) begin
        #1;
        ok_done    = bus.data_ok_o;
        stall_done = bus.mem_stall_o;
        rd_done    = bus.rdata_o;
        done       = 1;
      end else begin
        if (bus.data_req_o) begin
          req_cnt++;
          if (req_cnt == 1) begin
            req_addr  = bus.data_addr_o;
            req_wdata = bus.data_wdata_o;
            req_size  = bus.data_size_o;
            req_wr    = bus.data_wr_o;
          end
          if (req_cnt == addr_wait) begin
            bus.data_addr_ok_i = 1'b1;
            wait_cnt = 0;
            if (data_wait == 0) begin
              bus.data_data_ok_i = 1'b1;
              bus.data_rdata_i   = rd;
              resp_sent = 1;
            end
          end
        end else if (wait_cnt >= 0) begin
          wait_cnt++;
          if (wait_cnt == data_wait) begin
            bus.data_data_ok_i = 1'b1;
            bus.data_rdata_i   = rd;
            resp_sent = 1;
          end
        end
        #1;
        if (bus.mem_stall_o) stall_cnt++;
      end
      @(posedge clk);
      #1;
      bus.mem_en_i = 1'b0;
    end
    idle_inputs();
    if (!done) check_eq("txn_timeout", 32'd0, 32'd1);
  endtask

  int          sc;
  logic        okd, std, rwr;
  logic [31:0] rdd, ra, rw;
  logic [1:0]  rs;

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", {31'd0, bus.data_req_o}, 32'd0);
    check_eq("rst_ok", {31'd0, bus.data_ok_o}, 32'd0);
    check_eq("rst_stall", {31'd0, bus.mem_stall_o}, 32'd0);
    check_eq("rst_rdata", bus.rdata_o, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // LW 0x100: addr_ok on 2nd request cycle, data_ok 3 cycles later
    run_txn(`MEM_LOAD, SZ_WORD, 1'b0, 32'h100, 32'h0, 2, 3, 32'hDEADBEEF, -1,
            sc, okd, std, rdd, ra, rw, rs, rwr);
    check_eq("lw_stall_cycles", sc, 6);
    check_eq("lw_ok", {31'd0, okd}, 32'd1);
    check_eq("lw_done_stall", {31'd0, std}, 32'd0);
    check_eq("lw_rdata", rdd, 32'hDEADBEEF);
    check_eq("lw_addr", ra, 32'h100);
    check_eq("lw_wr", {31'd0, rwr}, 32'd0);
    #1;
    check_eq("lw_after_ok", {31'd0, bus.data_ok_o}, 32'd0);

    run_txn(`MEM_LOAD, SZ_BYTE, 1'b1, 32'h103, 32'h0, 1, 1, 32'h80FFFFFF, -1,
            sc, okd, std, rdd, ra, rw, rs, rwr);
    check_eq("lb_stall_cycles", sc, 3);
    check_eq("lb_rdata", rdd, 32'hFFFFFF80);
    check_eq("lb_size", {30'd0, rs}, 32'd0);

    run_txn(`MEM_LOAD, SZ_BYTE, 1'b0, 32'h103, 32'h0, 1, 1, 32'h80FFFFFF, -1,
            sc, okd, std, rdd, ra, rw, rs, rwr);
    check_eq("lbu_rdata", rdd, 32'h00000080);

    // SH with addr_ok and data_ok in the same cycle
    run_txn(`MEM_STOR, SZ_HALF, 1'b0, 32'h102, 32'h1234ABCD, 1, 0, 32'h0, -1,
            sc, okd, std, rdd, ra, rw, rs, rwr);
    check_eq("sh_wdata", rw, 32'hABCDABCD);
    check_eq("sh_size", {30'd0, rs}, 32'd1);
    check_eq("sh_wr", {31'd0, rwr}, 32'd1);
    check_eq("sh_stall_cycles", sc, 2);
    check_eq("sh_ok", {31'd0, okd}, 32'd1);
    check_eq("sh_rdata_kept", rdd, 32'h00000080);

    run_txn(`MEM_STOR, SZ_BYTE, 1'b0, 32'h101, 32'h000000A5, 1, 1, 32'h0, -1,
            sc, okd, std, rdd, ra, rw, rs, rwr);
    check_eq("sb_wdata", rw, 32'hA5A5A5A5);

    run_txn(`MEM_LOAD, SZ_HALF, 1'b1, 32'h102, 32'h0, 1, 2, 32'h80011234, -1,
            sc, okd, std, rdd, ra, rw, rs, rwr);
    check_eq("lh_rdata", rdd, 32'hFFFF8001);

    run_txn(`MEM_LOAD, SZ_HALF, 1'b0, 32'h100, 32'h0, 3, 1, 32'h1234F00D, -1,
            sc, okd, std, rdd, ra, rw, rs, rwr);
    check_eq("lhu_rdata", rdd, 32'h0000F00D);

    // misaligned accesses
    set_op(`MEM_LOAD, SZ_WORD, 1'b0, 32'h101, 32'h0);
    #1;
    check_eq("lw_mis_err", {31'd0, bus.addr_err_o}, 32'd1);
    check_eq("lw_mis_stall", {31'd0, bus.mem_stall_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check_eq("lw_mis_noreq", {31'd0, bus.data_req_o}, 32'd0);
    end
    bus.addr_i = 32'h102;
    #1;
    check_eq("lw_mis2_err", {31'd0, bus.addr_err_o}, 32'd1);
    bus.mem_size_i = SZ_HALF;
    bus.addr_i     = 32'h101;
    #1;
    check_eq("lh_mis_err", {31'd0, bus.addr_err_o}, 32'd1);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check_eq("mis_noreq_end", {31'd0, bus.data_req_o}, 32'd0);
    @(posedge clk);
    #1;

    // flush in WAIT: response drained, no data_ok_o, rdata_o held
    run_txn(`MEM_LOAD, SZ_WORD, 1'b0, 32'h200, 32'h0, 1, 2, 32'h11111111, 2,
            sc, okd, std, rdd, ra, rw, rs, rwr);
    check_eq("flw_ok", {31'd0, okd}, 32'd0);
    check_eq("flw_done_stall", {31'd0, std}, 32'd1);
    check_eq("flw_rdata", rdd, 32'h0000F00D);
    #1;
    check_eq("flw_idle_stall", {31'd0, bus.mem_stall_o}, 32'd0);
    check_eq("flw_idle_req", {31'd0, bus.data_req_o}, 32'd0);
    @(posedge clk);
    #1;

    // flush in REQ before addr_ok: request must stay up until accepted
    run_txn(`MEM_LOAD, SZ_WORD, 1'b0, 32'h204, 32'h0, 2, 1, 32'h22222222, 1,
            sc, okd, std, rdd, ra, rw, rs, rwr);
    check_eq("flr_ok", {31'd0, okd}, 32'd0);
    check_eq("flr_rdata", rdd, 32'h0000F00D);

    // flush in IDLE suppresses capture
    set_op(`MEM_LOAD, SZ_WORD, 1'b0, 32'h100, 32'h0);
    bus.flush_i = 1'b1;
    #1;
    check_eq("fli_stall", {31'd0, bus.mem_stall_o}, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check_eq("fli_noreq", {31'd0, bus.data_req_o}, 32'd0);

    // asynchronous reset while in WAIT
    @(posedge clk);
    #1;
    set_op(`MEM_LOAD, SZ_WORD, 1'b0, 32'h300, 32'h0);
    @(posedge clk);
    #1;
    bus.mem_en_i       = 1'b0;
    bus.data_addr_ok_i = 1'b1;
    @(posedge clk);
    #1;
    bus.data_addr_ok_i = 1'b0;
    #1;
    check_eq("rw_wait_stall", {31'd0, bus.mem_stall_o}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rw_req", {31'd0, bus.data_req_o}, 32'd0);
    check_eq("rw_stall", {31'd0, bus.mem_stall_o}, 32'd0);
    check_eq("rw_ok", {31'd0, bus.data_ok_o}, 32'd0);
    check_eq("rw_rdata", bus.rdata_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.data_data_ok_i = 1'b1;
    bus.data_rdata_i   = 32'h55555555;
    #1;
    check_eq("stray_ok", {31'd0, bus.data_ok_o}, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check_eq("stray_stall", {31'd0, bus.mem_stall_o}, 32'd0);
    check_eq("stray_req", {31'd0, bus.data_req_o}, 32'd0);
    check_eq("stray_ok2", {31'd0, bus.data_ok_o}, 32'd0);
    check_eq("stray_rdata", bus.rdata_o, 32'h0);
    @(posedge clk);
    #1;

    run_txn(`MEM_LOAD, SZ_WORD, 1'b0, 32'h300, 32'h0, 1, 1, 32'hCAFEF00D, -1,
            sc, okd, std, rdd, ra, rw, rs, rwr);
    check_eq("post_rst_ok", {31'd0, okd}, 32'd1);
    check_eq("post_rst_rdata", rdd, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of the data bus; the data width is fixed at 32.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 mem_en_i  in  1  MEM-stage instruction is a load or store.
REQ-005 mem_type_i  in  2  `MEM_LOAD / `MEM_STOR (common.vh encoding).
REQ-006 mem_size_i  in  2  0=byte, 1=half, 2=word.
REQ-007 mem_signed_i  in  1  sign-extend load result.
REQ-008 addr_i  in  ADDR_W  effective address.
REQ-009 wdata_i  in  32  store data, LSB-aligned.
REQ-010 flush_i  in  1  pipeline flush (exception/redirect).
REQ-011 data_req_o, data_wr_o  out  1 each  bus request, write enable.
REQ-012 data_size_o  out  2; data_addr_o  out  ADDR_W; data_wdata_o  out  32.
REQ-013 data_addr_ok_i, data_data_ok_i  in  1 each; data_rdata_i  in  32.
REQ-014 mem_stall_o  out  1  feeds stall_ctrl mem_stall_i.
REQ-015 data_ok_o  out  1  feeds stall_ctrl data_ok.
REQ-016 rdata_o  out  32  aligned, extended load result.
REQ-017 addr_err_o  out  1  misaligned access (AdEL/AdES source).

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-019 IDLE, mem_en_i=1, no misalignment, flush_i=0: capture addr, type, size, signed, wdata; go to REQ; mem_stall_o=1 combinationally in that cycle.
REQ-020 Misalignment SHALL be word with addr[1:0]!=0 or half with addr[0]!=0; while in IDLE it asserts addr_err_o combinationally, issues no request and does not assert mem_stall_o.
REQ-021 REQ: data_req_o=1 and all data_* outputs held from captured registers until data_addr_ok_i=1; then WAIT, or DONE directly if data_data_ok_i=1 in the same cycle.
REQ-022 WAIT: on data_data_ok_i=1 latch the extended read data and go to DONE.
REQ-023 DONE: data_ok_o=1 and mem_stall_o=0 for exactly one cycle, rdata_o valid; next state IDLE.
REQ-024 mem_stall_o SHALL be 1 in REQ and WAIT, and in DONE when the drop flag is set.
REQ-025 Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged; data_size_o = captured size.
REQ-026 Load: byte lane addr[1:0], half lane addr[1]; zero- or sign-extend to 32 per mem_signed_i; store completions leave rdata_o unchanged.
REQ-027 flush_i in REQ SHALL NOT drop data_req_o before data_addr_ok_i (bus rule); it sets a drop flag instead.
REQ-028 flush_i in WAIT or DONE, or a set drop flag: the response is consumed, data_ok_o suppressed, rdata_o unchanged, the FSM returns to IDLE, and the flag clears.
REQ-029 flush_i in IDLE SHALL suppress a new capture that cycle.
REQ-030 At most one outstanding bus transaction at any time.

Reset
REQ-031 rst=1 SHALL force IDLE, clear the drop flag and capture registers, and drive rdata_o=0, data_req_o=0, data_ok_o=0 and mem_stall_o=0 immediately, independent of clk.
REQ-032 rst asserted mid-transaction SHALL abandon it; a late data_data_ok_i after release SHALL be ignored in IDLE.

Structure
REQ-033 The package mem_pkg SHALL hold the state enum, the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the lane-select helper constants; MEM_LOAD/MEM_STOR remain in common.vh.
REQ-034 The combinational sub-module load_align (lane select plus extend) SHALL be instantiated once.

Verification
REQ-035 LW addr 0x100, addr_ok after 2 cycles, data_ok after 3 with 0xDEADBEEF -> stall 1 for 6 cycles, then data_ok_o pulse and rdata_o=0xDEADBEEF.
REQ-036 LB signed addr 0x103, rdata 0x80FFFFFF -> rdata_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-037 SH addr 0x102 wdata 0x1234ABCD -> data_wdata_o=0xABCDABCD, data_size_o=1, data_wr_o=1.
REQ-038 LW addr 0x101 -> addr_err_o=1, data_req_o never asserts, mem_stall_o=0.
REQ-039 flush_i in WAIT, data_ok 2 cycles later -> no data_ok_o pulse, rdata_o unchanged, IDLE afterwards.
REQ-040 rst pulse in WAIT -> outputs 0 asynchronously; stray data_data_ok_i after release -> no state change.
